// File: rtl/arb_val_rdy_mux_pkg.sv
// Shared definitions for the arb_val_rdy_mux merge stage.
//   - arb_mux_state_e : output-register occupancy (EMPTY / FULL)
//   - clog2           : constant function sizing the source-index field
// Optional feature macro used by the top level: ARB_VAL_RDY_MUX_SRCID_EN.
package arb_val_rdy_mux_pkg;

    typedef enum logic {
        ARB_MUX_EMPTY = 1'b0,
        ARB_MUX_FULL  = 1'b1
    } arb_mux_state_e;

    // Smallest r with 2**r >= n; n is at least 2 here, so r is at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_val_rdy_mux_rr.sv
// Round-robin arbiter for arb_val_rdy_mux.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   reqs       : per-port request vector
//   update_en  : a grant was consumed this cycle; advance priority
//   grants     : one-hot grant (zero only when no request is present)
// The priority register is one-hot; reset value selects port 0 first.
module arb_val_rdy_mux_rr
    import arb_val_rdy_mux_pkg::*;
#(
    parameter int p_num_reqs = 2
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] reqs,
    input  logic                  update_en,
    output logic [p_num_reqs-1:0] grants
);

    logic [p_num_reqs-1:0] prio;
    logic                  carry;
    logic                  en;
    logic                  gnt;

    // Variable-priority kill chain laid out twice end to end instead of as a
    // loop: the first copy starts at the priority bit, the second copy picks
    // up requests below it. Keeps the logic free of a combinational cycle.
    always_comb begin
        grants = '0;
        carry  = 1'b0;
        en     = 1'b0;
        gnt    = 1'b0;
        for (int i = 0; i < 2 * p_num_reqs; i++) begin
            if (i < p_num_reqs) begin
                en = prio[i % p_num_reqs] | carry;
            end else begin
                en = carry;
            end
            gnt                       = en & reqs[i % p_num_reqs];
            grants[i % p_num_reqs]    = grants[i % p_num_reqs] | gnt;
            carry                     = en & ~reqs[i % p_num_reqs];
        end
    end

    // Winner moves to lowest priority: the port after it becomes highest.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= p_num_reqs'(1);
        end else if (update_en) begin
            prio <= {grants[p_num_reqs-2:0], grants[p_num_reqs-1]};
        end
    end

endmodule

// File: rtl/arb_val_rdy_mux.sv
// Buffered N-to-1 val/rdy merge with round-robin fairness.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_val  [N]         : producer valids
//   in_rdy  [N]         : producer readies, one-hot or zero
//   in_msg  [N*W]       : port i at [(i+1)*W-1 : i*W]
//   out_val / out_rdy   : consumer handshake, out_val from the output register
//   out_msg [W]         : registered message
//   out_srcid           : port that supplied out_msg (only with
//                         ARB_VAL_RDY_MUX_SRCID_EN defined)
//
// state         | meaning
// --------------+------------------------------------------
// ARB_MUX_EMPTY | output register holds nothing
// ARB_MUX_FULL  | output register holds a message for out
module arb_val_rdy_mux
    import arb_val_rdy_mux_pkg::*;
#(
    parameter int p_num_reqs  = 2,
    parameter int p_msg_nbits = 32
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             in_val,
    output logic [p_num_reqs-1:0]             in_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
    output logic                              out_val,
    input  logic                              out_rdy,
    output logic [p_msg_nbits-1:0]            out_msg
`ifdef ARB_VAL_RDY_MUX_SRCID_EN
    ,
    output logic [clog2(p_num_reqs)-1:0]      out_srcid
`endif
);

    arb_mux_state_e         state;
    arb_mux_state_e         state_next;
    logic                   can_accept;
    logic                   xfer;
    logic [p_num_reqs-1:0]  grants;
    logic [p_msg_nbits-1:0] msg_sel;
    logic [p_msg_nbits-1:0] msg_reg;

    arb_val_rdy_mux_rr #(
        .p_num_reqs (p_num_reqs)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .reqs      (in_val),
        .update_en (xfer),
        .grants    (grants)
    );

    assign can_accept = (state == ARB_MUX_EMPTY) || (out_rdy && (state == ARB_MUX_FULL));
    // Explicit reset gate: the state register only clears on the edge.
    assign in_rdy     = reset ? '0 : (grants & {p_num_reqs{can_accept}});
    assign xfer       = |(in_val & in_rdy);
    assign out_val    = (state == ARB_MUX_FULL);
    assign out_msg    = msg_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_MUX_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_MUX_EMPTY: begin
                if (xfer) begin
                    state_next = ARB_MUX_FULL;
                end
            end
            ARB_MUX_FULL: begin
                if (out_rdy && !xfer) begin
                    state_next = ARB_MUX_EMPTY;
                end
            end
            default: state_next = ARB_MUX_EMPTY;
        endcase
    end

    // AND-OR select; grants is one-hot so at most one term is non-zero.
    always_comb begin
        msg_sel = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            msg_sel = msg_sel | (in_msg[i*p_msg_nbits +: p_msg_nbits] & {p_msg_nbits{grants[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_reg <= '0;
        end else if (xfer) begin
            msg_reg <= msg_sel;
        end
    end

`ifdef ARB_VAL_RDY_MUX_SRCID_EN
    localparam int SRC_W = clog2(p_num_reqs);

    logic [SRC_W-1:0] src_sel;
    logic [SRC_W-1:0] src_reg;

    always_comb begin
        src_sel = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (grants[i]) begin
                src_sel = src_sel | SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_reg <= '0;
        end else if (xfer) begin
            src_reg <= src_sel;
        end
    end

    assign out_srcid = src_reg;
`endif

endmodule

// File: tb/tb_arb_val_rdy_mux.sv
// Directed bench for arb_val_rdy_mux with four 32-bit ports.
module tb_arb_val_rdy_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             reset;
    logic [N-1:0]     in_val;
    logic [N-1:0]     in_rdy;
    logic [N*W-1:0]   in_msg;
    logic             out_val;
    logic             out_rdy;
    logic [W-1:0]     out_msg;
`ifdef ARB_VAL_RDY_MUX_SRCID_EN
    logic [1:0]       out_srcid;
`endif

    arb_val_rdy_mux #(
        .p_num_reqs  (N),
        .p_msg_nbits (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg)
`ifdef ARB_VAL_RDY_MUX_SRCID_EN
        ,
        .out_srcid (out_srcid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                rst;
        logic [N-1:0]        val;
        logic                ordy;
        logic [N-1:0][W-1:0] msg;
        logic [N-1:0]        exp_rdy;
        logic                chk_out;
        logic                exp_oval;
        logic                chk_msg;
        logic [W-1:0]        exp_msg;
        logic [1:0]          exp_src;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t v(
        input logic rst, input logic [N-1:0] val, input logic ordy,
        input logic [W-1:0] m0, input logic [W-1:0] m1,
        input logic [W-1:0] m2, input logic [W-1:0] m3,
        input logic [N-1:0] erdy, input logic chko, input logic eoval,
        input logic chkm, input logic [W-1:0] emsg, input logic [1:0] esrc);
        vec_t r;
        r.rst      = rst;
        r.val      = val;
        r.ordy     = ordy;
        r.msg      = {m3, m2, m1, m0};
        r.exp_rdy  = erdy;
        r.chk_out  = chko;
        r.exp_oval = eoval;
        r.chk_msg  = chkm;
        r.exp_msg  = emsg;
        r.exp_src  = esrc;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic eoval, input logic chkm,
                             input logic [W-1:0] emsg, input logic [1:0] esrc);
        check({tag, ".out_val"}, W'(out_val), W'(eoval));
        if (chkm) begin
            check({tag, ".out_msg"}, out_msg, emsg);
`ifdef ARB_VAL_RDY_MUX_SRCID_EN
            check({tag, ".out_srcid"}, W'(out_srcid), W'(esrc));
`else
            if (esrc > 2'd3) $display("unreachable");
`endif
        end
    endtask

    initial begin
        bit got_rdy;

        //            rst val     ordy m0            m1            m2     m3     erdy    co ov cm emsg          src
        vecs[0]  = v(1, 4'b0011, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 0, 1, 32'h0,        0);
        vecs[1]  = v(1, 4'b0011, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 0, 1, 32'h0,        0);
        vecs[2]  = v(0, 4'b1111, 1, 32'hF0,       32'hF1,       32'hF2, 32'hF3, 4'b0001, 1, 0, 0, 32'h0,      0);
        vecs[3]  = v(0, 4'b1111, 1, 32'hF0,       32'hF1,       32'hF2, 32'hF3, 4'b0010, 1, 1, 1, 32'hF0,     0);
        vecs[4]  = v(0, 4'b1111, 1, 32'hF0,       32'hF1,       32'hF2, 32'hF3, 4'b0100, 1, 1, 1, 32'hF1,     1);
        vecs[5]  = v(0, 4'b1111, 1, 32'hF0,       32'hF1,       32'hF2, 32'hF3, 4'b1000, 1, 1, 1, 32'hF2,     2);
        vecs[6]  = v(0, 4'b1111, 1, 32'hF0,       32'hF1,       32'hF2, 32'hF3, 4'b0001, 1, 1, 1, 32'hF3,     3);
        vecs[7]  = v(0, 4'b0000, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 1, 1, 32'hF0,       0);
        vecs[8]  = v(0, 4'b0000, 0, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 0, 0, 32'h0,        0);
        vecs[9]  = v(0, 4'b0010, 0, 32'h0,        32'hA5A5A5A5, 32'h0, 32'h0, 4'b0010, 1, 0, 0, 32'h0,        0);
        for (int i = 10; i <= 14; i++) begin
            vecs[i] = v(0, 4'b0011, 0, 32'hC00,  32'hA5A5A5A5, 32'h0, 32'h0, 4'b0000, 1, 1, 1, 32'hA5A5A5A5, 1);
        end
        vecs[15] = v(0, 4'b0011, 1, 32'hC00,      32'hA5A5A5A5, 32'h0, 32'h0, 4'b0001, 1, 1, 1, 32'hA5A5A5A5, 1);
        vecs[16] = v(0, 4'b0000, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 1, 1, 32'hC00,      0);
        vecs[17] = v(0, 4'b0100, 1, 32'h0,        32'h0,        32'h11, 32'h0, 4'b0100, 1, 0, 0, 32'h0,       0);
        vecs[18] = v(0, 4'b0100, 1, 32'h0,        32'h0,        32'h22, 32'h0, 4'b0100, 1, 1, 1, 32'h11,      2);
        vecs[19] = v(0, 4'b0100, 1, 32'h0,        32'h0,        32'h33, 32'h0, 4'b0100, 1, 1, 1, 32'h22,      2);
        vecs[20] = v(0, 4'b1001, 1, 32'h50,       32'h0,        32'h0, 32'h53, 4'b1000, 1, 1, 1, 32'h33,      2);
        vecs[21] = v(0, 4'b1001, 1, 32'h50,       32'h0,        32'h0, 32'h53, 4'b0001, 1, 1, 1, 32'h53,      3);
        vecs[22] = v(0, 4'b0000, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 1, 1, 32'h50,       0);
        vecs[23] = v(0, 4'b0000, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 0, 0, 32'h0,        0);
        vecs[24] = v(0, 4'b0010, 0, 32'h0,        32'hDEAD,     32'h0, 32'h0, 4'b0010, 1, 0, 0, 32'h0,        0);
        vecs[25] = v(1, 4'b0010, 0, 32'h0,        32'hDEAD,     32'h0, 32'h0, 4'b0000, 0, 0, 0, 32'h0,        0);
        vecs[26] = v(0, 4'b0000, 1, 32'h0,        32'h0,        32'h0, 32'h0, 4'b0000, 1, 0, 1, 32'h0,        0);
        vecs[27] = v(0, 4'b0011, 1, 32'h77,       32'h78,       32'h0, 32'h0, 4'b0001, 1, 0, 0, 32'h0,        0);

        reset   = 1'b1;
        in_val  = '0;
        in_msg  = '0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset   = vecs[i].rst;
            in_val  = vecs[i].val;
            out_rdy = vecs[i].ordy;
            in_msg  = vecs[i].msg;
            @(negedge clk);
            check($sformatf("vec%0d.in_rdy", i), W'(in_rdy), W'(vecs[i].exp_rdy));
            if (vecs[i].chk_out) begin
                check_out($sformatf("vec%0d", i), vecs[i].exp_oval, vecs[i].chk_msg,
                          vecs[i].exp_msg, vecs[i].exp_src);
            end
            @(posedge clk);
            #1;
        end

        // Hold under backpressure with no requests: message from port 0 stays.
        in_val  = '0;
        in_msg  = '0;
        out_rdy = 1'b0;
        @(negedge clk);
        check_out("hold", 1'b1, 1'b1, 32'h77, 2'd0);
        @(posedge clk);
        #1;

        // Simultaneous dequeue and enqueue from port 2 (priority points at port 1).
        in_val  = 4'b0100;
        in_msg  = {32'h0, 32'hBEEF, 32'h0, 32'h0};
        out_rdy = 1'b1;
        got_rdy = 1'b0;
        for (int c = 0; c < 10 && !got_rdy; c++) begin
            @(negedge clk);
            if (in_rdy == 4'b0100) begin
                got_rdy = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("swap.rdy_wait", W'(got_rdy), W'(1'b1));
        check_out("swap", 1'b1, 1'b1, 32'h77, 2'd0);
        @(posedge clk);
        #1;
        in_val = '0;
        in_msg = '0;
        @(negedge clk);
        check_out("swap_next", 1'b1, 1'b1, 32'hBEEF, 2'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out("drained", 1'b0, 1'b0, 32'h0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_val_rdy_mux.md
# arb_val_rdy_mux

Buffered N-to-1 val/rdy merge stage: accepts messages from `p_num_reqs` independent val/rdy producers, selects one per cycle with round-robin fairness, and holds the winner in a one-entry output register that drives a single val/rdy consumer. It sits directly downstream of the round-robin arbitration logic and turns its one-hot grants into an actual message transfer. It is used wherever several sources share one channel, such as memory request ports or network injection.

## Interface
- `p_num_reqs`, 2: number of input ports; legal range 2 to 16.
- `p_msg_nbits`, 32: message width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_val` input `p_num_reqs`: per-port valid.
- `in_rdy` output `p_num_reqs`: per-port ready, one-hot or zero.
- `in_msg` input `p_num_reqs*p_msg_nbits`: port i occupies bits `[(i+1)*p_msg_nbits-1 : i*p_msg_nbits]`.
- `out_val` output 1: output register holds a message.
- `out_rdy` input 1: consumer accepts.
- `out_msg` output `p_msg_nbits`: registered message.
- `out_srcid` output `clog2(p_num_reqs)`: index of the port that supplied `out_msg`. Present only under the macro below.

## Operation
- **State:**
  - 2-state FSM: EMPTY and FULL.
  - Output data register.
  - One-hot priority register of width `p_num_reqs`; reset value 1, meaning port 0 has highest priority.
- **can_accept** = (state == EMPTY) || (out_rdy && state == FULL).
- **Grant:** round-robin over `in_val` starting from the priority bit, wrapping from `p_num_reqs-1` to 0. Exactly one grant whenever any `in_val` is high.
- **in_rdy** = grant & {can_accept}. An input transfer happens on port i when `in_val[i] && in_rdy[i]`.
- **On a transfer:**
  - The register loads `in_msg[i]`.
  - The state becomes or stays FULL.
  - priority becomes grant rotated left by one, so the winner drops to lowest priority.
- **No transfer:** priority holds.
- **FSM transitions:**
  - EMPTY → FULL on a transfer.
  - FULL → EMPTY when out_rdy is high and there is no transfer.
  - FULL → FULL (new data) on simultaneous dequeue and enqueue.
  - FULL holds while out_rdy is low.
- **Outputs:**
  - out_val = (state == FULL).
  - out_msg is the register contents; its value is don't-care while out_val is 0.
- **Combinational dependence:** in_rdy depends on in_val and out_rdy. Producers must not make in_val depend on in_rdy.

## Timing
- Latency: an accepted message appears on out_val/out_msg the cycle after the transfer.
- Throughput: one message per cycle under continuous out_rdy.
- **Reset values:**
  - out_val 0.
  - in_rdy all 0 while reset is asserted.
  - priority 1, state EMPTY.
  - out_msg register 0.
- Reset mid-operation discards the held message; the cycle after reset deasserts, out_val = 0.
- **Backpressure:** FULL with out_rdy = 0 forces all in_rdy to 0. The held message stays stable until the cycle it is dequeued.
- With no in_val high: no transfer, priority unchanged, FULL drains to EMPTY on out_rdy.

## Configuration
- `ARB_VAL_RDY_MUX_SRCID_EN` defined:
  - A `clog2(p_num_reqs)`-bit source-index register is loaded alongside the message.
  - It is driven on `out_srcid`; reset value 0.
- Undefined: the register and the `out_srcid` port are absent. All other behaviour is identical.

## Structure
- **Shared package/header:**
  - FSM encodings ARB_MUX_EMPTY = 1'b0, ARB_MUX_FULL = 1'b1.
  - The `clog2` constant function used for the srcid width.
- **Sub-module `arb_val_rdy_mux_rr`:**
  - Contains the priority register and the replicated (non-circular) variable-priority kill chain.
  - Inputs: `reqs`, `update_en`. Outputs: `grants`.
  - Priority updates only when `update_en` is high.
- **Top level:** FSM, data/srcid registers, one-hot-to-index encoder, and message AND-OR select.

## Test plan
- **Reset:** assert reset 2 cycles with in_val = 2'b11 → in_rdy = 0, out_val = 0; first cycle after reset, port 0 is granted (in_rdy = 2'b01).
- **Fairness:** N = 4, all in_val held high, out_rdy = 1 → grant order 0, 1, 2, 3, 0. out_msg follows one cycle later at 1 message/cycle; out_srcid = 0, 1, 2, 3 when the macro is enabled.
- **Backpressure:** fill with 0xA5A5A5A5 from port 1, out_rdy = 0 for 5 cycles → out_msg stable, in_rdy = 0, priority unchanged. out_rdy = 1 → dequeue, and a pending port 0 request is accepted in the same cycle.
- **Sparse requests:** N = 4, only port 2 valid, sending 0x11, 0x22, 0x33 → accepted back-to-back. Then ports 0 and 3 valid together → port 3 is granted first, since priority points to port 3 after port 2 won.
- **Drain:** a single message with out_rdy = 1 and no further requests → out_val high for exactly 1 cycle, then EMPTY.
- **Reset mid-stream:** reset asserted while FULL with out_rdy = 0 → next cycle out_val = 0, and the held message is never observed.
